epp_host_port: RTL and testbench
================================

// Module: epp_host_port
// PURPOSE
//  Upstream front end for the NAND sequencer. Terminates the Digilent-style EPP
//  parallel port: synchronises strobes and data, owns the EPP address register
//  and epp_wait_n handshake. Converts each EPP data cycle into one request/response
//  transaction on a simple valid/ready bus that the NAND command/address/data/busy
//  sequencer consumes. The EPP address selects the sequencer operation.
// PARAMETERS
//  TIMEOUT  1023  clk10 cycles allowed per data cycle from req_valid rise to completion
//  AUTOINC  0     1 = address register increments (8'hFF wraps to 8'h00) after each completed data cycle
// PORTS
//  clk10        in     1  system clock (10 MHz, from DCM)
//  rst          in     1  asynchronous, active-high reset
//  epp_astb_n   in     1  EPP address strobe, asynchronous to clk10
//  epp_dstb_n   in     1  EPP data strobe, asynchronous to clk10
//  epp_wr_n     in     1  EPP direction: 0 = host write, 1 = host read
//  epp_wait_n   out    1  EPP handshake; 1 = cycle acknowledged
//  epp_dq       inout  8  EPP data bus
//  req_valid    out    1  transaction request to sequencer
//  req_write    out    1  1 = host write, 0 = host read
//  req_addr     out    8  current EPP address register
//  req_wdata    out    8  host write data (valid with req_valid)
//  req_ready    in     1  sequencer accepts request (req_valid & req_ready)
//  rsp_valid    in     1  read-data completion strobe from sequencer
//  rsp_rdata    in     8  read data, sampled when rsp_valid
//  timeout_err  out    1  sticky: a data cycle timed out
//  err_clr      in     1  synchronous clear of timeout_err
// BEHAVIOUR
//  - Reset values: epp_wait_n=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0,
//    timeout_err=0, read-data register=0, epp_dq released (Z), FSM=IDLE, timer=0.
//  - epp_astb_n, epp_dstb_n, epp_wr_n and epp_dq each pass through two clk10 flops
//    (_s). All decisions use the _s versions only.
//  - epp_dq is driven with the read-data register only when epp_wr_n_s=1 and the FSM
//    is in ACK or ADDR_ACK. Otherwise epp_dq is Z.
//  - FSM states: IDLE, ADDR_ACK, REQ, WAIT_RSP, ACK.
//  - IDLE:
//    - epp_astb_n_s=0: on a write, load req_addr<=epp_d_s. On a read, load the
//      read-data register<=req_addr. Go to ADDR_ACK.
//    - epp_dstb_n_s=0 (and astb high): latch req_write<=~epp_wr_n_s and
//      req_wdata<=epp_d_s, set req_valid=1, clear the timer, go to REQ.
//    - Both strobes low together: address strobe wins.
//  - ADDR_ACK: epp_wait_n=1. When both strobes are high, go to IDLE with
//    epp_wait_n=0.
//  - REQ: hold req_valid and all req_* fields stable until req_valid&req_ready.
//    - On accept: req_valid<=0. Writes go to ACK. Reads go to WAIT_RSP.
//  - WAIT_RSP: on rsp_valid, load read-data<=rsp_rdata and go to ACK. rsp_valid is
//    not sampled in the accept cycle itself.
//  - Timer increments every cycle in REQ/WAIT_RSP. On reaching TIMEOUT:
//    - force req_valid<=0 and read-data<=8'hFF;
//    - set timeout_err;
//    - go to ACK.
//  - ACK: epp_wait_n=1. When epp_dstb_n_s=1: epp_wait_n<=0, apply AUTOINC to
//    req_addr, go to IDLE.
//  - Latency: epp_wait_n and req_valid rise one clk10 edge after IDLE sees the
//    synchronised strobe (3 edges after the pin edge). epp_wait_n falls one edge
//    after the released strobe is seen.
//  - Host releases the strobe early (in REQ/WAIT_RSP): the request is not retracted.
//    The FSM completes, enters ACK, sees the strobe high, and returns to IDLE next
//    edge without further effect.
//  - err_clr and a timeout in the same cycle: timeout_err=1 (set wins).
//  - rst asserted mid-transaction: all outputs return to reset values immediately,
//    req_valid drops without handshake, and the sequencer must tolerate the
//    abandoned request.
// TESTING
//  1. Addr write 8'h43, then addr read -> req_addr=8'h43; epp_dq reads 8'h43 while
//     epp_wait_n=1; no req_valid pulse.
//  2. Data write 8'hFF with req_ready tied 1 -> exactly one req_valid cycle,
//     req_write=1, req_wdata=8'hFF, req_addr=8'h43; epp_wait_n rises next edge.
//  3. Data read, rsp_valid with rsp_rdata=8'hA5 5 cycles after accept -> epp_dq=8'hA5
//     during ACK; epp_wait_n drops one edge after epp_dstb_n_s rises.
//  4. Data read, sequencer never responds (TIMEOUT=16) -> ACK after 16 cycles,
//     epp_dq=8'hFF, timeout_err=1 until err_clr pulse.
//  5. AUTOINC=1, req_addr=8'hFF, two data writes -> req_addr 8'hFF then 8'h00; next
//     cycle 8'h01.
//  6. rst pulse while in WAIT_RSP -> same cycle epp_wait_n=0, req_valid=0, epp_dq=Z;
//     following EPP cycle completes normally.

Source files
------------

// File: rtl/epp_host_port.sv
// epp_host_port
//   Upstream front end for the NAND sequencer. Terminates a Digilent-style EPP
//   parallel port and turns every EPP data cycle into one request/response
//   transaction on a valid/ready bus. The EPP address register selects the
//   sequencer operation.
//
//   Ports
//     clk10, rst                  10 MHz clock, asynchronous active-high reset
//     epp_astb_n/dstb_n/wr_n      EPP strobes and direction (async to clk10)
//     epp_wait_n                  EPP handshake, 1 = cycle acknowledged
//     epp_dq[7:0]                 bidirectional EPP data bus
//     req_valid/write/addr/wdata  request to sequencer, held until req_ready
//     req_ready                   sequencer accepts request
//     rsp_valid/rsp_rdata         read-data completion from sequencer
//     timeout_err, err_clr        sticky data-cycle timeout flag and its clear
module epp_host_port #(
   parameter int TIMEOUT = 1023,
   parameter bit AUTOINC = 1'b0
) (
   input  logic       clk10,
   input  logic       rst,
   input  logic       epp_astb_n,
   input  logic       epp_dstb_n,
   input  logic       epp_wr_n,
   output logic       epp_wait_n,
   inout  wire  [7:0] epp_dq,
   output logic       req_valid,
   output logic       req_write,
   output logic [7:0] req_addr,
   output logic [7:0] req_wdata,
   input  logic       req_ready,
   input  logic       rsp_valid,
   input  logic [7:0] rsp_rdata,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ADDR_ACK, REQ, WAIT_RSP, ACK} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [7:0]    rd_data;

   // two-flop synchronisers; strobes and direction reset to their idle level
   // so that reset release never looks like a host cycle
   logic [1:0] astb_sr, dstb_sr, wr_sr;
   logic [7:0] d_meta, epp_d_s;
   logic       epp_astb_n_s, epp_dstb_n_s, epp_wr_n_s;

   always_ff @(posedge clk10 or posedge rst) begin
      if (rst) begin
         astb_sr <= 2'b11;
         dstb_sr <= 2'b11;
         wr_sr   <= 2'b11;
         d_meta  <= 8'h00;
         epp_d_s <= 8'h00;
      end else begin
         astb_sr <= {astb_sr[0], epp_astb_n};
         dstb_sr <= {dstb_sr[0], epp_dstb_n};
         wr_sr   <= {wr_sr[0], epp_wr_n};
         d_meta  <= epp_dq;
         epp_d_s <= d_meta;
      end
   end

   assign epp_astb_n_s = astb_sr[1];
   assign epp_dstb_n_s = dstb_sr[1];
   assign epp_wr_n_s   = wr_sr[1];

   // drive the bus only while acknowledging a host read
   assign epp_dq = (epp_wr_n_s && (state == ACK || state == ADDR_ACK)) ? rd_data : 8'bz;

   always_ff @(posedge clk10 or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         rd_data     <= 8'h00;
         epp_wait_n  <= 1'b0;
         req_valid   <= 1'b0;
         req_write   <= 1'b0;
         req_addr    <= 8'h00;
         req_wdata   <= 8'h00;
         timeout_err <= 1'b0;
      end else begin
         // a timeout later in this block overrides the clear
         if (err_clr)
            timeout_err <= 1'b0;

         if ((state == REQ || state == WAIT_RSP) && timer == T_LAST) begin
            // give up: acknowledge the host with 8'hFF and flag the error
            req_valid   <= 1'b0;
            rd_data     <= 8'hFF;
            timeout_err <= 1'b1;
            epp_wait_n  <= 1'b1;
            state       <= ACK;
         end else begin
            case (state)
               IDLE: begin
                  if (!epp_astb_n_s) begin
                     if (!epp_wr_n_s)
                        req_addr <= epp_d_s;
                     else
                        rd_data <= req_addr;
                     epp_wait_n <= 1'b1;
                     state      <= ADDR_ACK;
                  end else if (!epp_dstb_n_s) begin
                     req_write <= ~epp_wr_n_s;
                     req_wdata <= epp_d_s;
                     req_valid <= 1'b1;
                     timer     <= '0;
                     state     <= REQ;
                  end
               end
               ADDR_ACK: begin
                  if (epp_astb_n_s && epp_dstb_n_s) begin
                     epp_wait_n <= 1'b0;
                     state      <= IDLE;
                  end
               end
               REQ: begin
                  timer <= timer + 1'b1;
                  if (req_ready) begin
                     req_valid <= 1'b0;
                     if (req_write) begin
                        epp_wait_n <= 1'b1;
                        state      <= ACK;
                     end else begin
                        state <= WAIT_RSP;
                     end
                  end
               end
               WAIT_RSP: begin
                  timer <= timer + 1'b1;
                  if (rsp_valid) begin
                     rd_data    <= rsp_rdata;
                     epp_wait_n <= 1'b1;
                     state      <= ACK;
                  end
               end
               ACK: begin
                  // an early strobe release simply lands here and falls through
                  if (epp_dstb_n_s) begin
                     epp_wait_n <= 1'b0;
                     if (AUTOINC)
                        req_addr <= req_addr + 8'h01;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_epp_host_port.sv
// Directed bench for epp_host_port. Host EPP cycles are driven from one
// initial block; a scoreboard queue holds the request each host data cycle
// should produce and is checked when the sequencer side accepts it. A second
// instance with AUTOINC=1 shares all stimulus.
module tb_epp_host_port;

   typedef struct packed {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
   } req_t;

   logic       clk10 = 1'b0;
   logic       rst;
   logic       epp_astb_n, epp_dstb_n, epp_wr_n;
   logic       req_ready, rsp_valid, err_clr;
   logic [7:0] rsp_rdata;
   logic       tb_drv;
   logic [7:0] tb_d;
   wire  [7:0] dq, dq_ai;

   logic       epp_wait_n, req_valid, req_write, timeout_err;
   logic [7:0] req_addr, req_wdata;
   logic       ai_wait_n, ai_valid, ai_write, ai_terr;
   logic [7:0] ai_addr, ai_wdata;

   int         checks = 0;
   int         failures = 0;
   int         vcnt = 0;
   int         rsp_delay = -1;
   logic [7:0] rsp_val = 8'h00;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] ai_acc = 8'h00;
   req_t       sb_q[$];
   logic [7:0] rd_q[$];

   always #50 clk10 = ~clk10;

   assign dq    = tb_drv ? tb_d : 8'bz;
   assign dq_ai = tb_drv ? tb_d : 8'bz;

   epp_host_port #(.TIMEOUT(16), .AUTOINC(1'b0)) dut (
      .clk10(clk10), .rst(rst), .epp_astb_n(epp_astb_n), .epp_dstb_n(epp_dstb_n),
      .epp_wr_n(epp_wr_n), .epp_wait_n(epp_wait_n), .epp_dq(dq),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .timeout_err(timeout_err), .err_clr(err_clr));

   epp_host_port #(.TIMEOUT(16), .AUTOINC(1'b1)) dut_ai (
      .clk10(clk10), .rst(rst), .epp_astb_n(epp_astb_n), .epp_dstb_n(epp_dstb_n),
      .epp_wr_n(epp_wr_n), .epp_wait_n(ai_wait_n), .epp_dq(dq_ai),
      .req_valid(ai_valid), .req_write(ai_write), .req_addr(ai_addr),
      .req_wdata(ai_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .timeout_err(ai_terr), .err_clr(err_clr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // sequencer-side monitor: scoreboard check at every accept
   always @(negedge clk10) begin
      req_t e;
      if (req_valid) vcnt++;
      if (req_valid && req_ready) begin
         chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("req_write", 32'(req_write), 32'(e.w));
            chk("req_addr", 32'(req_addr), 32'(e.a));
            if (e.w) chk("req_wdata", 32'(req_wdata), 32'(e.d));
         end
         ai_acc = ai_addr;
      end
   end

   // read responder: answers rsp_delay cycles after a read is accepted
   initial begin
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      forever begin
         @(negedge clk10);
         if (req_valid && req_ready && !req_write && rsp_delay >= 0) begin
            repeat (rsp_delay) @(negedge clk10);
            rsp_valid = 1'b1;
            rsp_rdata = rsp_val;
            @(negedge clk10);
            rsp_valid = 1'b0;
         end
      end
   end

   task automatic wait_for(input logic val, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk10);
         n++;
      end while (epp_wait_n !== val && n < 200);
      chk(tag, 32'(epp_wait_n), 32'(val));
   endtask

   task automatic host_addr(input logic wr, input logic [7:0] a, output logic [7:0] rd);
      int n;
      epp_wr_n   = ~wr;
      tb_d       = a;
      tb_drv     = wr;
      epp_astb_n = 1'b0;
      wait_for(1'b1, "addr_wait_rise", n);
      chk("addr_rise_lat", 32'(n), 32'd3);
      rd = dq;
      epp_astb_n = 1'b1;
      wait_for(1'b0, "addr_wait_fall", n);
      chk("addr_fall_lat", 32'(n), 32'd3);
      tb_drv = 1'b0;
      if (wr) m_addr = a;
   endtask

   task automatic host_data(input logic wr, input logic [7:0] wd, input logic [7:0] erd,
                            output int rise, output logic te);
      int         fall;
      req_t       e;
      logic [7:0] x;
      e.w = wr;
      e.a = m_addr;
      e.d = wd;
      sb_q.push_back(e);
      if (!wr) rd_q.push_back(erd);
      vcnt       = 0;
      epp_wr_n   = ~wr;
      tb_d       = wd;
      tb_drv     = wr;
      epp_dstb_n = 1'b0;
      wait_for(1'b1, "data_wait_rise", rise);
      te = timeout_err;
      if (!wr) begin
         x = rd_q.pop_front();
         chk("host_rdata", 32'(dq), 32'(x));
      end
      epp_dstb_n = 1'b1;
      wait_for(1'b0, "data_wait_fall", fall);
      chk("data_fall_lat", 32'(fall), 32'd3);
      tb_drv = 1'b0;
   endtask

   initial begin
      int         rise;
      logic       te;
      logic [7:0] r;
      req_t       e;
      rst = 1'b1; epp_astb_n = 1'b1; epp_dstb_n = 1'b1; epp_wr_n = 1'b1;
      req_ready = 1'b1; err_clr = 1'b0; tb_drv = 1'b0; tb_d = 8'h00;
      repeat (3) @(negedge clk10);
      // reset state
      chk("rst_wait_n", 32'(epp_wait_n), 32'd0);
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_req_write", 32'(req_write), 32'd0);
      chk("rst_req_addr", 32'(req_addr), 32'd0);
      chk("rst_req_wdata", 32'(req_wdata), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      tb_d = 8'h3C; tb_drv = 1'b1; #1;
      chk("rst_dq_released", 32'(dq), 32'h3C);
      tb_drv = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk10);

      // address write then read back
      vcnt = 0;
      host_addr(1'b1, 8'h43, r);
      host_addr(1'b0, 8'h00, r);
      chk("addr_readback", 32'(r), 32'h43);
      chk("req_addr_43", 32'(req_addr), 32'h43);
      chk("addr_no_req", 32'(vcnt), 32'd0);

      // data write, ready tied high
      host_data(1'b1, 8'hFF, 8'h00, rise, te);
      chk("wr_one_valid", 32'(vcnt), 32'd1);
      chk("wr_rise_lat", 32'(rise), 32'd4);

      // request held stable while the sequencer stalls
      req_ready = 1'b0;
      fork
         host_data(1'b1, 8'h5A, 8'h00, rise, te);
         begin
            repeat (8) @(negedge clk10);
            chk("hold_valid", 32'(req_valid), 32'd1);
            chk("hold_wdata", 32'(req_wdata), 32'h5A);
            req_ready = 1'b1;
         end
      join

      // data read answered 5 cycles after accept
      rsp_delay = 5; rsp_val = 8'hA5;
      host_data(1'b0, 8'h00, 8'hA5, rise, te);
      chk("rd_rise_lat", 32'(rise), 32'd9);
      chk("rd_no_timeout", 32'(te), 32'd0);

      // data read with no response: timeout after 16 cycles in REQ/WAIT_RSP
      rsp_delay = -1;
      host_data(1'b0, 8'h00, 8'hFF, rise, te);
      chk("to_rise_lat", 32'(rise), 32'd19);
      chk("to_err_set", 32'(te), 32'd1);
      repeat (3) @(negedge clk10);
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      @(negedge clk10);
      err_clr = 1'b0;
      chk("to_err_cleared", 32'(timeout_err), 32'd0);

      // timeout coincides with a held err_clr: set wins
      err_clr = 1'b1;
      host_data(1'b0, 8'h00, 8'hFF, rise, te);
      chk("to_set_wins", 32'(te), 32'd1);
      err_clr = 1'b0;
      @(negedge clk10);
      chk("to_err_clr_after", 32'(timeout_err), 32'd0);

      // auto-increment across the 8'hFF wrap
      host_addr(1'b1, 8'hFF, r);
      chk("ai_addr_ff", 32'(ai_addr), 32'hFF);
      host_data(1'b1, 8'h11, 8'h00, rise, te);
      chk("ai_acc_1", 32'(ai_acc), 32'hFF);
      host_data(1'b1, 8'h22, 8'h00, rise, te);
      chk("ai_acc_2", 32'(ai_acc), 32'h00);
      chk("ai_addr_next", 32'(ai_addr), 32'h01);
      chk("noai_addr", 32'(req_addr), 32'hFF);

      // reset while waiting for a read response
      rsp_delay = -1;
      e.w = 1'b0; e.a = m_addr; e.d = 8'h00;
      sb_q.push_back(e);
      epp_wr_n = 1'b1;
      epp_dstb_n = 1'b0;
      repeat (7) @(negedge clk10);
      rst = 1'b1; #1;
      chk("mid_rst_addr", 32'(req_addr), 32'h00);
      chk("mid_rst_wait_n", 32'(epp_wait_n), 32'd0);
      chk("mid_rst_valid", 32'(req_valid), 32'd0);
      tb_d = 8'h3C; tb_drv = 1'b1; #1;
      chk("mid_rst_dq", 32'(dq), 32'h3C);
      tb_drv = 1'b0;
      epp_dstb_n = 1'b1;
      repeat (2) @(negedge clk10);
      rst = 1'b0;
      m_addr = 8'h00;
      repeat (3) @(negedge clk10);
      rsp_delay = 2; rsp_val = 8'h3E;
      host_data(1'b0, 8'h00, 8'h3E, rise, te);
      chk("post_rst_rise", 32'(rise), 32'd6);
      host_data(1'b1, 8'h77, 8'h00, rise, te);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
